// File: rtl/ecall_io_ctrl_pkg.sv
// Shared definitions for the ecall console responder: read-service FSM states
// and the seven-segment hex font.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DELIVER      = 2'd3
  } state_t;

  localparam int unsigned DIGITS = 8;

  // Returns active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return {1'b1, seg};
  endfunction

endpackage

// File: rtl/ecall_io_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and stable
// level, with one-cycle press/release pulses on stable-level edges.
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse
);

  logic [1:0]  sync;
  logic        stable;
  logic [19:0] cnt;

  // NOTE: all state here updates with <= so every register samples the
  // pre-edge values; blocking assignments would chain the synchronizer stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync          <= 2'b00;
      stable        <= 1'b0;
      cnt           <= 20'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], btn};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= 20'd0;
      end else if (cnt == DEB_CYCLES - 20'd1) begin
        stable        <= ~stable;
        cnt           <= 20'd0;
        press_pulse   <= ~stable;
        release_pulse <= stable;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/ecall_io_ctrl.sv
// Board-side responder for CPU ecall console services: latches print values
// onto an 8-digit multiplexed display and answers read requests from switches.
module ecall_io_ctrl
  import io_pkg::*;
#(
  parameter int          SW_W       = 16,
  parameter logic [19:0] DEB_CYCLES = 20'd1000000,
  parameter logic [15:0] SCAN_DIV   = 16'd50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            print_req,
  input  logic [31:0]     print_data,
  input  logic            read_req,
  input  logic [SW_W-1:0] sw,
  input  logic            confirm_btn,
  output logic [31:0]     read_data,
  output logic            read_valid,
  output logic            cpu_stall,
  output logic [7:0]      seg_an,
  output logic [7:0]      seg_cat,
  output logic            busy
);

  state_t          state, state_next;
  logic            print_q, read_q;
  logic            print_rise, read_rise;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0]     disp_reg;
  logic            disp_on;
  logic [15:0]     scan_cnt;
  logic [2:0]      digit;
  logic            press, released;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk          (clk),
    .reset        (reset),
    .btn          (confirm_btn),
    .press_pulse  (press),
    .release_pulse(released)
  );

  assign print_rise = print_req & ~print_q;
  // Gated by reset so a read_req held high during reset cannot raise the
  // combinational stall while the FSM is forced to IDLE.
  assign read_rise  = read_req & ~read_q & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      print_q   <= 1'b0;
      read_q    <= 1'b0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      read_data <= 32'd0;
      disp_reg  <= 32'd0;
      disp_on   <= 1'b0;
      scan_cnt  <= 16'd0;
      digit     <= 3'd0;
    end else begin
      state   <= state_next;
      print_q <= print_req;
      read_q  <= read_req;
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (print_rise) begin
        disp_reg <= print_data;
        disp_on  <= 1'b1;
      end
      if (state == WAIT_PRESS && press) read_data <= 32'(sw_sync);
      if (scan_cnt == SCAN_DIV - 16'd1) begin
        scan_cnt <= 16'd0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    read_valid = 1'b0;
    cpu_stall  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        cpu_stall = read_rise;
        if (read_rise) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        cpu_stall = 1'b1;
        if (press) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        cpu_stall = 1'b1;
        if (released) state_next = DELIVER;
      end
      DELIVER: begin
        read_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    seg_an  = 8'hFF;
    seg_cat = 8'hFF;
    if (disp_on) begin
      seg_an  = ~(8'd1 << digit);
      seg_cat = hex_to_seg(disp_reg[digit*4 +: 4]);
    end
  end

endmodule

// File: tb/tb_ecall_io_ctrl.sv
// Self-checking bench for ecall_io_ctrl with small debounce/scan parameters
// and a cycle-count based reference model of display and read behaviour.
module tb_ecall_io_ctrl;

  localparam int SW_W = 16;
  localparam int DEB  = 4;
  localparam int SCAN = 4;

  logic            clk, reset;
  logic            print_req, read_req, confirm_btn;
  logic [31:0]     print_data;
  logic [SW_W-1:0] sw;
  logic [31:0]     read_data;
  logic            read_valid, cpu_stall, busy;
  logic [7:0]      seg_an, seg_cat;

  int n_vec, n_err;
  int unsigned n_edges;
  logic [31:0] exp_disp;
  logic        exp_on;
  logic [7:0]  font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  ecall_io_ctrl #(.SW_W(SW_W), .DEB_CYCLES(20'(DEB)), .SCAN_DIV(16'(SCAN))) dut (
    .clk(clk), .reset(reset), .print_req(print_req), .print_data(print_data),
    .read_req(read_req), .sw(sw), .confirm_btn(confirm_btn), .read_data(read_data),
    .read_valid(read_valid), .cpu_stall(cpu_stall), .seg_an(seg_an),
    .seg_cat(seg_cat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the active digit is (edges / SCAN) mod 8.
  always @(posedge clk or negedge reset)
    if (!reset) n_edges <= 0;
    else        n_edges <= n_edges + 1;

  task automatic test_reset();
    #3;
    n_vec++;
    if ({read_data, read_valid, cpu_stall, busy, seg_an, seg_cat} !== {32'd0, 3'b000, 16'hFFFF}) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b st=%b busy=%b an=%h cat=%h want 0/0/0/0/FF/FF",
               read_data, read_valid, cpu_stall, busy, seg_an, seg_cat);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_vec++;
      if ({seg_an, seg_cat, read_valid, cpu_stall, busy} !== {16'hFFFF, 3'b000}) begin
        n_err++;
        $display("FAIL idle_blank: cycle %0d got an=%h cat=%h v=%b st=%b busy=%b want FF/FF/0/0/0",
                 i, seg_an, seg_cat, read_valid, cpu_stall, busy);
      end
    end
  endtask

  task automatic do_print(input logic [31:0] data);
    @(negedge clk);
    print_req  = 1'b1;
    print_data = data;
    @(negedge clk);
    exp_disp   = data;
    exp_on     = 1'b1;
    // Level held high with changing data must not retrigger.
    repeat (2) begin
      print_data = $urandom;
      @(negedge clk);
    end
    print_req = 1'b0;
  endtask

  task automatic test_display(input int cycles);
    int          idx;
    logic [7:0]  want_an, want_cat;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      idx      = int'((n_edges / SCAN) % 8);
      want_an  = exp_on ? ~(8'd1 << idx) : 8'hFF;
      want_cat = exp_on ? font[exp_disp[idx*4 +: 4]] : 8'hFF;
      n_vec++;
      if (seg_an !== want_an || seg_cat !== want_cat) begin
        n_err++;
        $display("FAIL display: digit %0d got an=%h cat=%h want an=%h cat=%h",
                 idx, seg_an, seg_cat, want_an, want_cat);
      end
    end
  endtask

  task automatic start_read();
    @(negedge clk);
    read_req = 1'b1;
    #1;
    n_vec++;
    if (cpu_stall !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_on_edge: got stall=%b busy=%b want 1/0", cpu_stall, busy);
    end
    @(negedge clk);
    n_vec++;
    if (cpu_stall !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_registered: got stall=%b busy=%b want 1/1", cpu_stall, busy);
    end
  endtask

  task automatic pulse_btn(input int hold);
    @(negedge clk) confirm_btn = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if (cpu_stall !== 1'b1 || read_valid !== 1'b0) begin
        n_err++;
        $display("FAIL held_press: got stall=%b valid=%b want 1/0", cpu_stall, read_valid);
      end
    end
    confirm_btn = 1'b0;
  endtask

  task automatic wait_valid(input logic [31:0] want);
    int nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_vec++;
      if (read_valid === 1'b1) begin
        nv++;
        if (read_data !== want || cpu_stall !== 1'b0) begin
          n_err++;
          $display("FAIL deliver: got data=%h stall=%b want data=%h stall=0",
                   read_data, cpu_stall, want);
        end
      end else if (nv == 0 && cpu_stall !== 1'b1) begin
        n_err++;
        $display("FAIL stall_before_deliver: got stall=%b want 1", cpu_stall);
      end else if (nv != 0 && (cpu_stall !== 1'b0 || busy !== 1'b0 || read_data !== want)) begin
        n_err++;
        $display("FAIL after_deliver: got stall=%b busy=%b data=%h want 0/0/%h",
                 cpu_stall, busy, read_data, want);
      end
    end
    n_vec++;
    if (nv != 1) begin
      n_err++;
      $display("FAIL valid_count: got %0d pulses want 1", nv);
    end
  endtask

  task automatic drop_read();
    @(negedge clk) read_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_directed();
    sw = 16'h00A5;
    start_read();
    pulse_btn(6);
    wait_valid(32'h0000_00A5);
    drop_read();
  endtask

  task automatic test_read_random();
    logic [SW_W-1:0] v;
    for (int k = 0; k < 4; k++) begin
      v  = SW_W'($urandom);
      sw = v;
      start_read();
      pulse_btn(int'($urandom_range(6, 12)));
      wait_valid(32'(v));
      drop_read();
    end
  endtask

  task automatic test_bounce();
    sw = 16'h3C5A;
    start_read();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (cpu_stall !== 1'b1 || read_valid !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL bounce: got stall=%b valid=%b busy=%b want 1/0/1", cpu_stall, read_valid, busy);
      end
      confirm_btn = ((i / 2) % 2 == 0);
    end
    confirm_btn = 1'b0;
    repeat (8) @(negedge clk);
    pulse_btn(6);
    wait_valid(32'h0000_3C5A);
    drop_read();
  endtask

  task automatic test_held_button();
    logic [SW_W-1:0] v;
    @(negedge clk) confirm_btn = 1'b1;
    repeat (10) @(negedge clk);
    start_read();
    repeat (4) @(negedge clk);
    confirm_btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_vec++;
      if (cpu_stall !== 1'b1 || read_valid !== 1'b0) begin
        n_err++;
        $display("FAIL early_press_counted: got stall=%b valid=%b want 1/0", cpu_stall, read_valid);
      end
    end
    v  = SW_W'($urandom);
    sw = v;
    pulse_btn(7);
    wait_valid(32'(v));
    drop_read();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    sw = 16'hBEEF;
    start_read();
    pulse_btn(6);
    @(negedge clk) read_req = 1'b0;
    @(negedge clk);
    d          = $urandom;
    read_req   = 1'b1;
    print_req  = 1'b1;
    print_data = d;
    #1;
    n_vec++;
    if (cpu_stall !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL second_edge: got stall=%b busy=%b want 1/1", cpu_stall, busy);
    end
    @(negedge clk);
    exp_disp  = d;
    exp_on    = 1'b1;
    print_req = 1'b0;
    wait_valid(32'h0000_BEEF);
    drop_read();
  endtask

  task automatic test_reset_mid_read();
    sw = 16'h1111;
    start_read();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_disp = 32'd0;
    exp_on   = 1'b0;
    n_vec++;
    if ({cpu_stall, busy, read_valid, seg_an, read_data} !== {3'b000, 8'hFF, 32'd0}) begin
      n_err++;
      $display("FAIL async_reset: got stall=%b busy=%b v=%b an=%h data=%h want 0/0/0/FF/0",
               cpu_stall, busy, read_valid, seg_an, read_data);
    end
    @(negedge clk) read_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) confirm_btn = 1'b1;
    repeat (6) @(negedge clk);
    confirm_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_vec++;
      if (read_valid !== 1'b0 || cpu_stall !== 1'b0 || busy !== 1'b0 || read_data !== 32'd0) begin
        n_err++;
        $display("FAIL abandoned_read: got v=%b stall=%b busy=%b data=%h want 0/0/0/0",
                 read_valid, cpu_stall, busy, read_data);
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    print_req = 1'b0; print_data = 32'd0; read_req = 1'b0;
    sw = '0; confirm_btn = 1'b0;
    n_vec = 0; n_err = 0;
    exp_disp = 32'd0; exp_on = 1'b0;

    test_reset();
    do_print(32'h1234_ABCD);
    test_display(40);
    for (int k = 0; k < 3; k++) begin
      do_print($urandom);
      test_display(32);
    end
    test_read_directed();
    test_read_random();
    test_bounce();
    test_held_button();
    test_back_to_back();
    test_display(32);
    test_reset_mid_read();
    test_display(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecall_io_ctrl.md
Name: ecall_io_ctrl

Overview:
Board-side responder for the CPU's ecall console services. It takes print requests (a7=1), latches the value and shows it as 8 hex digits on the multiplexed seven-segment display. It also services read requests (a7=5): it stalls the CPU until the user sets the switches and presses and releases the confirm button, then returns the switch value. It sits between the CPU top and the board pins.

Parameters:
SW_W, 16, switch input width; zero-extended to 32 bits on return.
DEB_CYCLES, 20'd1000000, consecutive stable cycles required to accept a button level change.
SCAN_DIV, 16'd50000, clk cycles per display digit slot.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
print_req  input  1  level from the CPU print service; rising edge = new print
print_data  input  32  value to display, sampled on the print_req rising edge
read_req  input  1  level from the CPU read service; rising edge = new read
sw  input  SW_W  board switches, asynchronous
confirm_btn  input  1  board push button, active-high, asynchronous, bouncy
read_data  output  32  returned value for a0
read_valid  output  1  one-cycle pulse; read_data valid
cpu_stall  output  1  high while a read is outstanding
seg_an  output  8  digit anodes, active-low
seg_cat  output  8  cathodes {dp,g..a}, active-low; dp always off (1)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): FSM=IDLE; read_data=0; read_valid=0; cpu_stall=0; busy=0; disp_reg=0; disp_on=0; seg_an=8'hFF; seg_cat=8'hFF. All counters and synchronizers are cleared; button stable state is 0.
- Edge detect: registered copies of print_req and read_req. A rising edge is req & ~req_q. Levels held high do not retrigger.
- Print: on a print_req rising edge, in any FSM state, disp_reg<=print_data and disp_on<=1 in the next cycle. The next print overwrites it. Printing never stalls.
- Display: scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..7 and wraps to 0. Digit i shows disp_reg[4i+3:4i], and seg_an has bit i low. While disp_on=0, seg_an=8'hFF.
- Hex font is standard 0-F (b and d lowercase).
- Button path: 2-FF synchronizer feeds the debouncer. The counter resets whenever the synced level equals the stable level. When the counter reaches DEB_CYCLES-1, the stable level is toggled. press = stable rising edge; release = stable falling edge.
- sw path: 2-FF synchronizer. The value is captured on the press cycle.
- FSM:
  - IDLE: read_req rising edge -> WAIT_PRESS. cpu_stall goes to 1 in the same cycle the edge is seen (combinational from the edge) and is registered thereafter.
  - WAIT_PRESS: on press -> read_data<={zeros,sw_sync}, go to WAIT_RELEASE.
  - WAIT_RELEASE: on release -> DELIVER.
  - DELIVER: read_valid=1 for exactly this cycle, cpu_stall=0, then -> IDLE.
- cpu_stall=1 in WAIT_PRESS and WAIT_RELEASE. busy=1 in all states except IDLE.
- read_req rising edge while not IDLE is ignored (no queueing).
- A button press already in progress when the read starts does not count: the stable level must go high after entry to WAIT_PRESS.
- Simultaneous print and read edges: both are accepted in the same cycle.
- Reset asserted mid-read: the read is abandoned, stall drops immediately, and read_valid is not produced.
- read_data holds its value until the next capture.

Decomposition:
- Shared package (io_pkg): FSM state encoding (IDLE, WAIT_PRESS, WAIT_RELEASE, DELIVER as 2-bit localparams) and the hex-to-segment table as a function.
- One sub-module, btn_debounce: synchronizer, counter and stable level, with press/release pulse outputs and parameter DEB_CYCLES.
- Display scan and the FSM stay in the top.

Test Plan:
- Reset with small params (DEB_CYCLES=4, SCAN_DIV=4) -> all outputs at reset values, seg_an=FF; after 100 cycles still FF.
- print_req rises with print_data=32'h1234ABCD -> over 32 cycles seg_an steps FE,FD,...,7F. Cathodes show D,C,B,A,4,3,2,1 (e.g. digit 0 seg_cat=8'hA1, digit 7=8'hF9).
- Read: read_req rises -> cpu_stall=1 that cycle. sw=16'h00A5, confirm held 6 cycles then released for 6. Expect read_valid pulse exactly once, read_data=32'h000000A5, cpu_stall=0 on the valid cycle.
- Bounce: confirm toggles every 2 cycles for 20 cycles during WAIT_PRESS -> no press detected, stall stays 1. A clean press then completes the read.
- Second read_req edge during WAIT_RELEASE, plus a print edge in the same cycle -> read ignored (single read_valid), display updates.
- Assert reset in WAIT_PRESS -> cpu_stall=0 asynchronously, busy=0, no read_valid after release of reset.
